// File: rtl/mem_multi_ch_pkg.sv
// Shared types and defaults for the multi-channel word memory.
// The response struct is sized for the widest supported configuration; the top slices it down.
package mem_multi_ch_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_NUM_CH = 2;

  // Up to 8 channels and up to 256-bit words.
  localparam int MAX_CH_W   = 3;
  localparam int MAX_DATA_W = 256;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [MAX_CH_W-1:0]   ch;
    logic [MAX_DATA_W-1:0] rdata;
    logic                  error;
  } rsp_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_multi_ch_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, wrapping to 0.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  // Two passes avoid a variable index: first the upper segment, then the wrapped lower one.
  always_comb begin
    logic found;
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && req_i[j] && (j >= int'(ptr_i))) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = CH_W'(j);
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!found && req_i[j]) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = CH_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_multi_ch.sv
// Multi-channel DEPTH x DATA_W word memory with round-robin arbitration, byte-lane writes,
// range checking and a post-reset clear sweep. Responses come back one cycle after accept.
module mem_multi_ch
  import mem_multi_ch_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_CH = DEF_NUM_CH,
  localparam int CH_W  = ch_w(NUM_CH),
  localparam int BE_W  = DATA_W / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              req_valid_i,
  output logic [NUM_CH-1:0]              req_ready_o,
  input  logic [NUM_CH-1:0]              req_wr_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  req_wdata_i,
  input  logic [NUM_CH-1:0][BE_W-1:0]    req_be_i,
  output logic                           rsp_valid_o,
  output logic [CH_W-1:0]                rsp_ch_o,
  output logic [DATA_W-1:0]              rsp_rdata_o,
  output logic                           rsp_error_o,
  output logic                           init_done_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q;
  logic [IDX_W-1:0]  init_addr_q;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;
  logic              init_done_q;
  rsp_t              rsp_q;
  rsp_t              rsp_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  logic              accept;

  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_be;
  logic              in_range;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] rd_word;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Grants are only exposed while running and out of reset, so no accept can sneak into a reset edge.
  assign req_ready_o = ((state_q == ST_RUN) && !rst) ? gnt : '0;
  assign accept      = |req_ready_o;

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_wr    = req_wr_i[i];
        sel_addr  = req_addr_i[i];
        sel_wdata = req_wdata_i[i];
        sel_be    = req_be_i[i];
      end
    end
  end

  assign in_range = (sel_addr < ADDR_W'(DEPTH));
  assign sel_idx  = sel_addr[IDX_W-1:0];
  assign rd_word  = mem_q[sel_idx];

  assign ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

  // The single write port is shared: the clear sweep owns it in INIT, requests own it in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sel_idx;
    wr_data = sel_wdata;
    wr_be   = sel_be;
    if (state_q == ST_INIT) begin
      wr_en   = !rst;
      wr_idx  = init_addr_q;
      wr_data = '0;
      wr_be   = '1;
    end else begin
      wr_en   = accept && sel_wr && in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Tag/data/error only update on accept; otherwise they hold while valid drops.
  always_comb begin
    rsp_d       = rsp_q;
    rsp_d.valid = accept;
    if (accept) begin
      rsp_d.ch    = MAX_CH_W'(gnt_idx);
      rsp_d.error = !in_range;
      rsp_d.rdata = (!sel_wr && in_range) ? MAX_DATA_W'(rd_word) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          rsp_q <= rsp_d;
          if (init_addr_q == IDX_W'(DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
            init_addr_q <= '0;
          end else begin
            init_addr_q <= init_addr_q + 1'b1;
          end
        end
        ST_RUN: begin
          rsp_q <= rsp_d;
          if (accept) begin
            ptr_q <= ptr_d;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  assign rsp_valid_o = rsp_q.valid;
  assign rsp_ch_o    = rsp_q.ch[CH_W-1:0];
  assign rsp_rdata_o = rsp_q.rdata[DATA_W-1:0];
  assign rsp_error_o = rsp_q.error;
  assign init_done_o = init_done_q;

  // Upper struct bits beyond this configuration's widths are always zero.
  logic unused_rsp_bits;
  assign unused_rsp_bits = ^{rsp_q.ch, rsp_q.rdata};

endmodule

// File: tb/tb_mem_multi_ch.sv
// Directed bench for mem_multi_ch with DEPTH=16, NUM_CH=3: init timing, round-robin,
// byte enables, range errors and reset in the middle of traffic.
module tb_mem_multi_ch;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int NCH   = 3;
  localparam int CHW   = 2;
  localparam int BEW   = DW / 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NCH-1:0]            req_valid;
  logic [NCH-1:0]            req_ready;
  logic [NCH-1:0]            req_wr;
  logic [NCH-1:0][AW-1:0]    req_addr;
  logic [NCH-1:0][DW-1:0]    req_wdata;
  logic [NCH-1:0][BEW-1:0]   req_be;
  logic                      rsp_valid;
  logic [CHW-1:0]            rsp_ch;
  logic [DW-1:0]             rsp_rdata;
  logic                      rsp_error;
  logic                      init_done;

  mem_multi_ch #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .NUM_CH (NCH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_wr_i    (req_wr),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .rsp_valid_o (rsp_valid),
    .rsp_ch_o    (rsp_ch),
    .rsp_rdata_o (rsp_rdata),
    .rsp_error_o (rsp_error),
    .init_done_o (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_wr    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    req_valid[ch] = 1'b1;
    req_wr[ch]    = wr;
    req_addr[ch]  = addr;
    req_wdata[ch] = wdata;
    req_be[ch]    = be;
  endtask

  // Single-channel request: checks the grant, then the response one edge later.
  task automatic do_req(input vec_t v, input string name);
    logic [NCH-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[v.ch] = 1'b1;
    idle_all();
    set_req(v.ch, v.wr, v.addr, v.wdata, v.be);
    #1;
    check({name, ".ready"}, req_ready, exp_gnt);
    tick();
    idle_all();
    check({name, ".valid"}, rsp_valid, 1);
    check({name, ".ch"}, rsp_ch, v.ch);
    check({name, ".rdata"}, rsp_rdata, v.exp_rdata);
    check({name, ".error"}, rsp_error, v.exp_err);
  endtask

  vec_t        vt [10];
  logic [31:0] exp_mem [DEPTH];

  initial begin
    int   cnt;
    logic bad_ready;
    vec_t v;

    vt[0] = '{0, 1'b1, 32'd5,          32'hDEADBEEF, 4'hF,    32'h0,        1'b0};
    vt[1] = '{1, 1'b0, 32'd5,          32'h0,        4'h0,    32'hDEADBEEF, 1'b0};
    vt[2] = '{2, 1'b1, 32'd3,          32'hAABBCCDD, 4'b0101, 32'h0,        1'b0};
    vt[3] = '{0, 1'b0, 32'd3,          32'h0,        4'h0,    32'h00BB00DD, 1'b0};
    vt[4] = '{1, 1'b1, 32'd7,          32'h11223344, 4'h0,    32'h0,        1'b0};
    vt[5] = '{2, 1'b0, 32'd7,          32'h0,        4'h0,    32'h0,        1'b0};
    vt[6] = '{0, 1'b0, 32'd16,         32'h0,        4'h0,    32'h0,        1'b1};
    vt[7] = '{1, 1'b1, 32'hFFFF_FFFF,  32'h12345678, 4'hF,    32'h0,        1'b1};
    vt[8] = '{2, 1'b1, 32'd15,         32'hCAFEF00D, 4'b1000, 32'h0,        1'b0};
    vt[9] = '{1, 1'b0, 32'd15,         32'h0,        4'h0,    32'hCA000000, 1'b0};

    for (int a = 0; a < DEPTH; a++) exp_mem[a] = 32'h0;
    exp_mem[3]  = 32'h00BB00DD;
    exp_mem[5]  = 32'hDEADBEEF;
    exp_mem[15] = 32'hCA000000;

    // Reset, then all three channels request continuously from release.
    idle_all();
    rst = 1'b1;
    repeat (3) tick();
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.init_done", init_done, 0);
    check("rst.ready", req_ready, 0);
    set_req(0, 1'b0, 32'd0, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'd1, 32'h0, 4'h0);
    set_req(2, 1'b0, 32'd2, 32'h0, 4'h0);
    rst = 1'b0;
    cnt = 0;
    bad_ready = 1'b0;
    while (!init_done && cnt < 100) begin
      if (req_ready != '0 || rsp_valid) bad_ready = 1'b1;
      tick();
      cnt++;
    end
    check("init.cycles", cnt, DEPTH);
    check("init.ready_quiet", bad_ready, 0);

    for (int k = 0; k < 6; k++) begin
      check($sformatf("rr%0d.ready", k), req_ready, 3'b001 << (k % 3));
      tick();
      check($sformatf("rr%0d.valid", k), rsp_valid, 1);
      check($sformatf("rr%0d.ch", k), rsp_ch, k % 3);
      check($sformatf("rr%0d.rdata", k), rsp_rdata, 0);
      check($sformatf("rr%0d.error", k), rsp_error, 0);
    end
    idle_all();
    tick();
    check("hold.valid", rsp_valid, 0);
    check("hold.ch", rsp_ch, 2);

    // Freshly cleared array reads back zero everywhere.
    for (int a = 0; a < DEPTH; a++) begin
      v = '{a % 3, 1'b0, 32'(a), 32'h0, 4'h0, 32'h0, 1'b0};
      do_req(v, $sformatf("clr%0d", a));
    end

    for (int i = 0; i < 10; i++) do_req(vt[i], $sformatf("vec%0d", i));

    // Full sweep: only the legal writes changed anything.
    for (int a = 0; a < DEPTH; a++) begin
      v = '{0, 1'b0, 32'(a), 32'h0, 4'h0, exp_mem[a], 1'b0};
      do_req(v, $sformatf("sweep%0d", a));
    end

    // Reset lands while ch0 is presenting a read of a freshly written word.
    v = '{0, 1'b1, 32'd9, 32'h0000_0055, 4'hF, 32'h0, 1'b0};
    do_req(v, "pre_rst_wr");
    set_req(0, 1'b0, 32'd9, 32'h0, 4'h0);
    rst = 1'b1;
    #1;
    check("mid_rst.ready", req_ready, 0);
    tick();
    rst = 1'b0;
    check("mid_rst.valid", rsp_valid, 0);
    check("mid_rst.init_done", init_done, 0);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("reinit%0d.ready", i), req_ready, 0);
      check($sformatf("reinit%0d.done", i), init_done, 0);
      tick();
      check($sformatf("reinit%0d.valid", i), rsp_valid, 0);
    end
    check("reinit.done", init_done, 1);
    check("reinit.ready", req_ready, 3'b001);
    tick();
    idle_all();
    check("reinit_rd.valid", rsp_valid, 1);
    check("reinit_rd.ch", rsp_ch, 0);
    check("reinit_rd.rdata", rsp_rdata, 0);
    check("reinit_rd.error", rsp_error, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
